// File: rtl/regfile_pkg.sv
// Shared types and default widths for the parametrised register file.
package regfile_pkg;

    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux with init, zero-register and write-bypass masking.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [(2**ADDR_W)*DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          ready,
    input  logic                          byp_valid,
    input  logic [ADDR_W-1:0]             byp_addr,
    input  logic [DATA_W-1:0]             byp_data,
    output logic [DATA_W-1:0]             data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] sel;

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                sel = regs[i*DATA_W +: DATA_W];
            end
        end
    end

    // Zero-register forcing wins over bypass so r0 stays 0 even while written.
    always_comb begin
        data = sel;
        if (byp_valid && (addr == byp_addr)) begin
            data = byp_data;
        end
        if (!ready || ((ZERO_REG != 0) && (addr == '0))) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_seq_init.sv
// Parametrised register file with sequenced reg[i]=i initialisation.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
//
//   state    | meaning
//   RF_INIT  | writing reg[cnt]=cnt each clock, ready=0, reads return 0
//   RF_READY | ready=1, normal reads/writes, init_req restarts init
module regfile_seq_init
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_req,
    output logic                     ready,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_register,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] read_register,
    output logic [NUM_RD*DATA_W-1:0] read_data
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0]            regs [DEPTH];
    logic [DEPTH*DATA_W-1:0]      regs_flat;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [DATA_W-1:0]            wr_data;
    logic                         byp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = write_register;
        wr_data = write_data;
        case (state_q)
            RF_INIT: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = DATA_W'(cnt_q);
                if (cnt_q == CNT_LAST) begin
                    state_d = RF_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_READY: begin
                wr_en = reg_write && !((ZERO_REG != 0) && (write_register == '0));
                if (init_req) begin
                    state_d = RF_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready = (state_q == RF_READY);

    // Gating on reset drops a write whose edge coincides with reset assertion.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp_valid = ready && reg_write;
`else
    assign byp_valid = 1'b0;
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .regs      (regs_flat),
            .addr      (read_register[k*ADDR_W +: ADDR_W]),
            .ready     (ready),
            .byp_valid (byp_valid),
            .byp_addr  (write_register),
            .byp_data  (write_data),
            .data      (read_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_seq_init.sv
// Directed bench for regfile_seq_init; a ZERO_REG=0 copy runs alongside on shared stimulus.
module tb_regfile_seq_init;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        init_req;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [9:0]  read_register;
    logic        ready, ready_nz;
    logic [63:0] read_data, read_data_nz;

    int n_vec = 0;
    int n_bad = 0;
    int edges;

    always #5 clk = ~clk;

    regfile_seq_init #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .init_req(init_req), .ready(ready),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .read_register(read_register), .read_data(read_data)
    );

    regfile_seq_init #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
        .clk(clk), .reset(reset), .init_req(init_req), .ready(ready_nz),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .read_register(read_register), .read_data(read_data_nz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        read_register = {a1, a0};
        #1;
    endtask

    // Counts edges until ready rises, bounded so a stuck FSM still reaches the summary.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (ready) break;
        end
    endtask

    initial begin
        reset = 1'b1; init_req = 1'b0; reg_write = 1'b0;
        write_register = '0; write_data = '0; read_register = '0;

        // 1: reset, init length, init contents
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd0);
        rd(5'd5, 5'd31);
        chk("rst_rd0", read_data[31:0], 32'd0);
        reset = 1'b0;
        wait_ready(edges);
        chk("init_edges", 32'(edges), 32'd32);
        chk("init_edges_nz", 32'(ready_nz), 32'd1);
        rd(5'd5, 5'd31);
        chk("init_r5", read_data[31:0], 32'd5);
        chk("init_r31", read_data[63:32], 32'd31);
        rd(5'd0, 5'd17);
        chk("init_r0", read_data[31:0], 32'd0);
        chk("init_r17_nz", read_data_nz[63:32], 32'd17);

        // 2: write then read on both ports
        reg_write = 1'b1; write_register = 5'd7; write_data = 32'hDEADBEEF;
        tick();
        reg_write = 1'b0;
        rd(5'd7, 5'd7);
        chk("wr_r7_p0", read_data[31:0], 32'hDEADBEEF);
        chk("wr_r7_p1", read_data[63:32], 32'hDEADBEEF);

        // 3: register 0 behaviour with and without ZERO_REG
        reg_write = 1'b1; write_register = 5'd0; write_data = 32'h1234;
        tick();
        reg_write = 1'b0;
        rd(5'd0, 5'd7);
        chk("zr_r0", read_data[31:0], 32'd0);
        chk("nz_r0", read_data_nz[31:0], 32'h1234);

        // 4: same-cycle write/read of r9, and of r0
        reg_write = 1'b1; write_register = 5'd9; write_data = 32'hA5;
        rd(5'd9, 5'd5);
        chk("byp_r9", read_data[31:0], BYP ? 32'hA5 : 32'd9);
        chk("byp_r5", read_data[63:32], 32'd5);
        tick();
        reg_write = 1'b0;
        rd(5'd9, 5'd9);
        chk("post_r9", read_data[31:0], 32'hA5);
        reg_write = 1'b1; write_register = 5'd0; write_data = 32'h77;
        rd(5'd0, 5'd0);
        chk("byp_zr_r0", read_data[31:0], 32'd0);
        chk("byp_nz_r0", read_data_nz[31:0], BYP ? 32'h77 : 32'h1234);
        tick();
        reg_write = 1'b0;

        // 5: write plus init_req in one cycle, then full re-init
        reg_write = 1'b1; write_register = 5'd3; write_data = 32'h55; init_req = 1'b1;
        tick();
        reg_write = 1'b0; init_req = 1'b0;
        rd(5'd3, 5'd7);
        chk("req_ready", 32'(ready), 32'd0);
        chk("req_rd_init", read_data[31:0], 32'd0);
        chk("req_rd1_init", read_data[63:32], 32'd0);
        tick(); tick(); tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        edges = 0;
        while (edges < 40 && !ready) begin
            tick();
            edges++;
        end
        chk("reinit_edges", 32'(edges), 32'd28);
        rd(5'd3, 5'd7);
        chk("reinit_r3", read_data[31:0], 32'd3);
        chk("reinit_r7", read_data[63:32], 32'd7);
        tick();
        chk("no_queue_ready", 32'(ready), 32'd1);

        // 6: reset mid-init, reg_write held during init
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        reg_write = 1'b1; write_register = 5'd2; write_data = 32'hBAD;
        for (int i = 0; i < 10; i++) tick();
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready), 32'd0);
        tick(); tick();
        chk("rst_hold_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        wait_ready(edges);
        reg_write = 1'b0;
        chk("rst_mid_edges", 32'(edges), 32'd32);
        rd(5'd2, 5'd12);
        chk("ign_wr_r2", read_data[31:0], 32'd2);
        chk("ign_wr_r12", read_data[63:32], 32'd12);
        chk("ign_wr_r2_nz", read_data_nz[31:0], 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
